// File: rtl/imm_gen_if.sv
// imm_gen_if: handshake bundle between an instruction producer, the
// immediate-generator stage and its consumer.
//   in_valid/in_ready/in_ir/in_tag        : instruction into the stage
//   out_valid/out_ready                   : decoded entry out of the stage
//   out_imm/out_fmt/out_illegal/out_tag   : decoded entry payload
// master = the surrounding pipeline (drives inputs, accepts outputs)
// slave  = the immediate-generator stage itself
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_ir, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_ir, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator for decode.
// Classifies the instruction format, sign/zero-extends the immediate to
// XLEN and flags unsupported opcodes. A two-entry (main + skid) buffer
// keeps full throughput under back-pressure while in_ready stays a flop.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of both buffered entries
//   bus    : imm_gen_if.slave (in_* instruction side, out_* decoded side)
// out_fmt: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6 NONE.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int ZIMM_EN = 1,
  parameter int TAG_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  imm_gen_if.slave  bus
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_Z    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd6;

  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]     ir_p0;
  logic [6:0]      op_p0;
  logic [2:0]      f3_p0;
  logic            shift_p0;
  logic [XLEN-1:0] dec_imm_p0;
  logic [2:0]      dec_fmt_p0;
  logic            dec_ill_p0;

  assign ir_p0    = bus.in_ir;
  assign op_p0    = ir_p0[6:0];
  assign f3_p0    = ir_p0[14:12];
  assign shift_p0 = (f3_p0 == 3'b001) || (f3_p0 == 3'b101);

  // ---- p0: combinational decode of the presented instruction ----
  always_comb begin
    dec_imm_p0 = '0;
    dec_fmt_p0 = FMT_NONE;
    dec_ill_p0 = 1'b0;
    case (op_p0)
      7'b0010011: begin
        dec_fmt_p0 = FMT_I;
        // Shift immediates carry an unsigned shamt, 6 bits wide on RV64.
        if (shift_p0)
          dec_imm_p0 = (XLEN == 64) ? zext(ir_p0[25:20]) : zext({1'b0, ir_p0[24:20]});
        else
          dec_imm_p0 = sext(32'(signed'(ir_p0[31:20])));
      end
      7'b0000011, 7'b1100111, 7'b0001111: begin
        dec_fmt_p0 = FMT_I;
        dec_imm_p0 = sext(32'(signed'(ir_p0[31:20])));
      end
      7'b0100011: begin
        dec_fmt_p0 = FMT_S;
        dec_imm_p0 = sext(32'(signed'({ir_p0[31:25], ir_p0[11:7]})));
      end
      7'b1100011: begin
        dec_fmt_p0 = FMT_B;
        dec_imm_p0 = sext(32'(signed'({ir_p0[31], ir_p0[7], ir_p0[30:25],
                                       ir_p0[11:8], 1'b0})));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt_p0 = FMT_U;
        dec_imm_p0 = sext({ir_p0[31:12], 12'b0});
      end
      7'b1101111: begin
        dec_fmt_p0 = FMT_J;
        dec_imm_p0 = sext(32'(signed'({ir_p0[31], ir_p0[19:12], ir_p0[20],
                                       ir_p0[30:21], 1'b0})));
      end
      7'b1110011: begin
        // funct3[2] selects the CSR forms whose rs1 field is a 5-bit zimm.
        if ((ZIMM_EN != 0) && ir_p0[14]) begin
          dec_fmt_p0 = FMT_Z;
          dec_imm_p0 = zext({1'b0, ir_p0[19:15]});
        end else begin
          dec_fmt_p0 = FMT_I;
          dec_imm_p0 = sext(32'(signed'(ir_p0[31:20])));
        end
      end
      7'b0110011: dec_fmt_p0 = FMT_NONE;
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt_p0 = FMT_I;
          // Word shifts only ever use a 5-bit shamt.
          if (shift_p0)
            dec_imm_p0 = zext({1'b0, ir_p0[24:20]});
          else
            dec_imm_p0 = sext(32'(signed'(ir_p0[31:20])));
        end else begin
          dec_ill_p0 = 1'b1;
        end
      end
      7'b0111011: dec_ill_p0 = (XLEN != 64);
      default:    dec_ill_p0 = 1'b1;
    endcase
    if (ir_p0[1:0] != 2'b11) begin
      dec_ill_p0 = 1'b1;
      dec_fmt_p0 = FMT_NONE;
      dec_imm_p0 = '0;
    end
  end

  logic             main_vld_p1, skid_vld_p1, rdy_p1;
  logic [XLEN-1:0]  main_imm_p1, skid_imm_p1;
  logic [2:0]       main_fmt_p1, skid_fmt_p1;
  logic             main_ill_p1, skid_ill_p1;
  logic [TAG_W-1:0] main_tag_p1, skid_tag_p1;

  logic acc_p0, main_free_p0;
  logic main_vld_nxt, skid_vld_nxt;
  logic load_main_dec, load_main_skid, load_skid;

  // An input offered during flush is dropped even if it handshakes.
  assign acc_p0       = bus.in_valid & rdy_p1 & ~flush;
  assign main_free_p0 = ~main_vld_p1 | bus.out_ready;

  always_comb begin
    main_vld_nxt   = main_vld_p1;
    skid_vld_nxt   = skid_vld_p1;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (main_free_p0) begin
      // Skid has priority to keep FIFO order; rdy_p1 is low whenever it is full.
      if (skid_vld_p1) begin
        load_main_skid = 1'b1;
        main_vld_nxt   = 1'b1;
        skid_vld_nxt   = 1'b0;
      end else if (acc_p0) begin
        load_main_dec = 1'b1;
        main_vld_nxt  = 1'b1;
      end else begin
        main_vld_nxt = 1'b0;
      end
    end else if (acc_p0) begin
      load_skid    = 1'b1;
      skid_vld_nxt = 1'b1;
    end
  end

  // ---- p1: main/skid entries and registered ready ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
      main_imm_p1 <= '0;
      main_fmt_p1 <= FMT_NONE;
      main_ill_p1 <= 1'b0;
      main_tag_p1 <= '0;
      skid_imm_p1 <= '0;
      skid_fmt_p1 <= FMT_NONE;
      skid_ill_p1 <= 1'b0;
      skid_tag_p1 <= '0;
    end else begin
      main_vld_p1 <= main_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      rdy_p1      <= ~skid_vld_nxt;
      if (load_main_dec) begin
        main_imm_p1 <= dec_imm_p0;
        main_fmt_p1 <= dec_fmt_p0;
        main_ill_p1 <= dec_ill_p0;
        main_tag_p1 <= bus.in_tag;
      end else if (load_main_skid) begin
        main_imm_p1 <= skid_imm_p1;
        main_fmt_p1 <= skid_fmt_p1;
        main_ill_p1 <= skid_ill_p1;
        main_tag_p1 <= skid_tag_p1;
      end
      if (load_skid) begin
        skid_imm_p1 <= dec_imm_p0;
        skid_fmt_p1 <= dec_fmt_p0;
        skid_ill_p1 <= dec_ill_p0;
        skid_tag_p1 <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready    = rdy_p1;
  assign bus.out_valid   = main_vld_p1;
  assign bus.out_imm     = main_imm_p1;
  assign bus.out_fmt     = main_fmt_p1;
  assign bus.out_illegal = main_ill_p1;
  assign bus.out_tag     = main_tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] imm32; logic [2:0] f32; logic i32;
    logic [63:0] imm64; logic [2:0] f64; logic i64;
    logic [31:0] immnz; logic [2:0] fnz; logic inz;
    logic [7:0]  tag;
  } exp_t;

  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_ir;
  logic [7:0]  in_tag;
  int          n_test = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        vexp[NV];
  logic [31:0] vir[NV];

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(8)) if32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(8)) if64 ();
  imm_gen_if #(.XLEN(32), .TAG_W(8)) ifnz ();

  assign if32.in_valid = in_valid;  assign if32.in_ir = in_ir;
  assign if32.in_tag = in_tag;      assign if32.out_ready = out_ready;
  assign if64.in_valid = in_valid;  assign if64.in_ir = in_ir;
  assign if64.in_tag = in_tag;      assign if64.out_ready = out_ready;
  assign ifnz.in_valid = in_valid;  assign ifnz.in_ir = in_ir;
  assign ifnz.in_tag = in_tag;      assign ifnz.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1), .TAG_W(8)) u_x32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32));
  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1), .TAG_W(8)) u_x64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64));
  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(0), .TAG_W(8)) u_nz (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifnz));

  task automatic set_vec(input int i, input logic [31:0] ir,
                         input logic [31:0] a32, input logic [2:0] f32, input logic i32,
                         input logic [63:0] a64, input logic [2:0] f64, input logic i64,
                         input logic [31:0] anz, input logic [2:0] fnz, input logic inz);
    vir[i] = ir;
    vexp[i] = '{imm32: a32, f32: f32, i32: i32, imm64: a64, f64: f64, i64: i64,
                immnz: anz, fnz: fnz, inz: inz, tag: 8'h00};
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_test++;
    if ({if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag, if32.in_ready}
        !== {1'b0, 32'h0, 3'd6, 1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_x32 got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b want v=0 imm=0 fmt=6 ill=0 tag=0 rdy=1",
               if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag, if32.in_ready);
    end
    n_test++;
    if ({if64.out_valid, if64.out_imm, if64.out_fmt, if64.in_ready} !== {1'b0, 64'h0, 3'd6, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_x64 got v=%b imm=%h fmt=%0d rdy=%b want v=0 imm=0 fmt=6 rdy=1",
               if64.out_valid, if64.out_imm, if64.out_fmt, if64.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_test++;
    if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", if32.in_ready, if32.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_formats();
    int k = 0;
    int c = 0;
    exp_t e;
    out_ready = 1'b1;
    while ((k < NV || sb.size() != 0) && c < 60) begin
      if (k < NV) begin
        in_valid = 1'b1; in_ir = vir[k]; in_tag = 8'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (sb.size() != 0) begin
        n_test++;
        if (if32.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL fmt_latency got out_valid=%b want 1 (tag %h pending)", if32.out_valid, sb[0].tag);
        end
      end
      if (if32.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_test++; n_fail++;
          $display("FAIL fmt_spurious got tag=%h want no output", if32.out_tag);
        end else begin
          e = sb.pop_front();
          n_test += 3;
          if ({if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag} !== {e.imm32, e.f32, e.i32, e.tag}) begin
            n_fail++;
            $display("FAIL fmt_x32 got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag, e.imm32, e.f32, e.i32, e.tag);
          end
          if ({if64.out_imm, if64.out_fmt, if64.out_illegal, if64.out_tag} !== {e.imm64, e.f64, e.i64, e.tag}) begin
            n_fail++;
            $display("FAIL fmt_x64 got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     if64.out_imm, if64.out_fmt, if64.out_illegal, if64.out_tag, e.imm64, e.f64, e.i64, e.tag);
          end
          if ({ifnz.out_imm, ifnz.out_fmt, ifnz.out_illegal, ifnz.out_tag} !== {e.immnz, e.fnz, e.inz, e.tag}) begin
            n_fail++;
            $display("FAIL fmt_nozimm got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     ifnz.out_imm, ifnz.out_fmt, ifnz.out_illegal, ifnz.out_tag, e.immnz, e.fnz, e.inz, e.tag);
          end
        end
      end
      if (in_valid && if32.in_ready) begin
        e = vexp[k]; e.tag = in_tag; sb.push_back(e); k++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    n_test++;
    if (k != NV || sb.size() != 0) begin
      n_fail++;
      $display("FAIL fmt_drain got sent=%0d pending=%0d want sent=%0d pending=0", k, sb.size(), NV);
    end
  endtask

  task automatic test_back_pressure();
    int   k = 0;
    exp_t e;
    logic rdy_exp [8];
    rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      out_ready = (c >= 4);
      if (k < 3) begin
        in_valid = 1'b1; in_ir = vir[k]; in_tag = 8'(8'h21 + k);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_test++;
      if (if32.in_ready !== rdy_exp[c]) begin
        n_fail++;
        $display("FAIL bp_in_ready cycle %0d got %b want %b", c, if32.in_ready, rdy_exp[c]);
      end
      if (c >= 1 && c <= 3) begin
        n_test++;
        if (if32.out_valid !== 1'b1 || if32.out_tag !== 8'h21 || if32.out_imm !== vexp[0].imm32) begin
          n_fail++;
          $display("FAIL bp_hold cycle %0d got v=%b tag=%h imm=%h want v=1 tag=21 imm=%h",
                   c, if32.out_valid, if32.out_tag, if32.out_imm, vexp[0].imm32);
        end
      end
      if (c >= 4 && c <= 6) begin
        n_test++;
        if (if32.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_gap cycle %0d got out_valid=%b want 1", c, if32.out_valid);
        end
      end
      if (if32.out_valid && out_ready) begin
        n_test++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_spurious got tag=%h want no output", if32.out_tag);
        end else begin
          e = sb.pop_front();
          if ({if32.out_imm, if32.out_fmt, if32.out_tag} !== {e.imm32, e.f32, e.tag}) begin
            n_fail++;
            $display("FAIL bp_order got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                     if32.out_imm, if32.out_fmt, if32.out_tag, e.imm32, e.f32, e.tag);
          end
        end
      end
      if (in_valid && if32.in_ready) begin
        e = vexp[k]; e.tag = in_tag; sb.push_back(e); k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_test++;
    if (k != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain got sent=%0d pending=%0d want sent=3 pending=0", k, sb.size());
    end
  endtask

  task automatic test_flush();
    exp_t e;
    // Both entries full, then flush with an input offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = vir[0]; in_tag = 8'h31;
    @(posedge clk); #1;
    in_ir = vir[1]; in_tag = 8'h32;
    @(posedge clk); #1;
    flush = 1'b1; in_ir = vir[2]; in_tag = 8'h3F;
    @(negedge clk);
    n_test++;
    if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full got rdy=%b v=%b want rdy=0 v=1", if32.in_ready, if32.out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_test++;
    if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", if32.out_valid, if32.in_ready);
    end
    // Main full, flush while consuming it and while a new input handshakes.
    @(posedge clk); #1;
    in_valid = 1'b1; in_ir = vir[3]; in_tag = 8'h41;
    @(negedge clk);
    if (if32.in_ready) begin e = vexp[3]; e.tag = 8'h41; sb.push_back(e); end
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1; in_ir = vir[4]; in_tag = 8'h42;
    @(negedge clk);
    n_test++;
    if (!(if32.out_valid === 1'b1 && sb.size() == 1 && if32.out_tag === 8'h41 && if32.in_ready === 1'b1)) begin
      n_fail++;
      $display("FAIL flush_consume got v=%b tag=%h rdy=%b want v=1 tag=41 rdy=1",
               if32.out_valid, if32.out_tag, if32.in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_ir = vir[5]; in_tag = 8'h43;
    @(negedge clk);
    n_test++;
    if (if32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard got v=%b tag=%h want v=0", if32.out_valid, if32.out_tag);
    end
    if (if32.in_ready) begin e = vexp[5]; e.tag = 8'h43; sb.push_back(e); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_test++;
    if (sb.size() == 0 || if32.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after got v=%b pending=%0d want v=1 pending=1", if32.out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({if32.out_imm, if32.out_fmt, if32.out_tag} !== {e.imm32, e.f32, e.tag}) begin
        n_fail++;
        $display("FAIL flush_after got imm=%h fmt=%0d tag=%h want imm=%h fmt=%0d tag=%h",
                 if32.out_imm, if32.out_fmt, if32.out_tag, e.imm32, e.f32, e.tag);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = vir[8]; in_tag = 8'h51;
    @(posedge clk); #1;
    in_ir = vir[3]; in_tag = 8'h52;
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_test++;
    if ({if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag, if32.in_ready}
        !== {1'b0, 32'h0, 3'd6, 1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_x32 got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b want v=0 imm=0 fmt=6 ill=0 tag=0 rdy=1",
               if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag, if32.in_ready);
    end
    n_test++;
    if ({if64.out_valid, if64.out_imm, if64.out_fmt} !== {1'b0, 64'h0, 3'd6}) begin
      n_fail++;
      $display("FAIL arst_x64 got v=%b imm=%h fmt=%0d want v=0 imm=0 fmt=6",
               if64.out_valid, if64.out_imm, if64.out_fmt);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ir = vir[3]; in_tag = 8'h53;
    @(negedge clk);
    n_test++;
    if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_idle got v=%b rdy=%b want v=0 rdy=1", if32.out_valid, if32.in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_test++;
    if ({if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_tag} !== {1'b1, 32'h12345000, 3'd3, 8'h53}) begin
      n_fail++;
      $display("FAIL arst_first got v=%b imm=%h fmt=%0d tag=%h want v=1 imm=12345000 fmt=3 tag=53",
               if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_tag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ir = 32'h0; in_tag = 8'h0;
    //        ir            x32 imm/fmt/ill              x64 imm/fmt/ill                       no-zimm imm/fmt/ill
    set_vec(0,  32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0, 32'hFFFFFFFF, 3'd0, 1'b0);
    set_vec(1,  32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0, 32'hFFFFFFFC, 3'd1, 1'b0);
    set_vec(2,  32'hFE000CE3, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0);
    set_vec(3,  32'h123450B7, 32'h12345000, 3'd3, 1'b0, 64'h0000000012345000, 3'd3, 1'b0, 32'h12345000, 3'd3, 1'b0);
    set_vec(4,  32'hFFDFF06F, 32'hFFFFFFFC, 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0, 32'hFFFFFFFC, 3'd4, 1'b0);
    set_vec(5,  32'h4030D093, 32'h00000003, 3'd0, 1'b0, 64'h0000000000000003, 3'd0, 1'b0, 32'h00000003, 3'd0, 1'b0);
    set_vec(6,  32'h3002D073, 32'h00000005, 3'd5, 1'b0, 64'h0000000000000005, 3'd5, 1'b0, 32'h00000300, 3'd0, 1'b0);
    set_vec(7,  32'h0000000B, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000000, 3'd6, 1'b1, 32'h00000000, 3'd6, 1'b1);
    set_vec(8,  32'h800000B7, 32'h80000000, 3'd3, 1'b0, 64'hFFFFFFFF80000000, 3'd3, 1'b0, 32'h80000000, 3'd3, 1'b0);
    set_vec(9,  32'h0000001B, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000000, 3'd0, 1'b0, 32'h00000000, 3'd6, 1'b1);
    set_vec(10, 32'h0000003B, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000000, 3'd6, 1'b0, 32'h00000000, 3'd6, 1'b1);
    set_vec(11, 32'h00000033, 32'h00000000, 3'd6, 1'b0, 64'h0000000000000000, 3'd6, 1'b0, 32'h00000000, 3'd6, 1'b0);
    set_vec(12, 32'h00000010, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000000, 3'd6, 1'b1, 32'h00000000, 3'd6, 1'b1);
    set_vec(13, 32'h0230D093, 32'h00000003, 3'd0, 1'b0, 64'h0000000000000023, 3'd0, 1'b0, 32'h00000003, 3'd0, 1'b0);
    set_vec(14, 32'h0230D09B, 32'h00000000, 3'd6, 1'b1, 64'h0000000000000003, 3'd0, 1'b0, 32'h00000000, 3'd6, 1'b1);

    test_reset();
    test_formats();
    test_back_pressure();
    test_flush();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
